// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard/forwarding controller: shift-register scoreboard of in-flight writers from EX onward,
// producing registered forwarding selects, load-use stalls, branch flushes and memory-wait freezes.
module pipeline_hazard_scoreboard #(
    parameter int NUM_FWD_STAGES = 2,
    parameter int LOAD_FWD_STAGE = 2,
    parameter int REG_ADDR_W     = 5,
    parameter int CNT_W          = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic                  id_reg_write,
    input  logic                  id_is_load,
    input  logic                  id_mem_op,
    input  logic                  ex_branch_taken,
    input  logic                  dmem_ready,
    output logic                  stall_fetch,
    output logic                  stall_decode,
    output logic                  freeze_all,
    output logic                  flush_decode,
    output logic [2:0]            fwd_sel_rs1,
    output logic [2:0]            fwd_sel_rs2,
    output logic [CNT_W-1:0]      stall_count
);

    localparam int N = NUM_FWD_STAGES;

    // Only entries 0..N-1 can still be matched after the shift; the oldest entry is about to
    // drop and never forwards, so it is not stored. mem_q tracks the EX and MEM occupants only.
    logic [N-1:0]          vld_q;
    logic [N-1:0]          load_q;
    logic [REG_ADDR_W-1:0] rd_q [N];
    logic [1:0]            mem_q;

    logic [2:0]            fwd_sel_rs1_q, fwd_sel_rs1_d;
    logic [2:0]            fwd_sel_rs2_q, fwd_sel_rs2_d;
    logic [CNT_W-1:0]      stall_count_q, stall_count_d;

    logic [2:0]            pos1, pos2;
    logic                  haz1, haz2;
    logic                  freeze, flush, load_use, stall, issue;

    // Returns {load-use hazard, post-shift position}; the youngest match wins.
    function automatic logic [3:0] lookup(input logic [REG_ADDR_W-1:0] src, input logic used);
        logic [3:0] res;
        res = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (used && (src != '0) && vld_q[k] && (rd_q[k] == src)) begin
                res = {load_q[k] && (k + 1 < LOAD_FWD_STAGE), 3'(k + 1)};
            end
        end
        return res;
    endfunction

    always_comb begin
        {haz1, pos1}  = lookup(id_rs1_addr, id_rs1_used);
        {haz2, pos2}  = lookup(id_rs2_addr, id_rs2_used);
        freeze        = mem_q[1] & ~dmem_ready;
        flush         = ex_branch_taken & ~freeze & rst_n;
        load_use      = id_valid & (haz1 | haz2) & ~freeze & ~flush;
        stall         = freeze | load_use;
        issue         = id_valid & ~stall & ~flush;
        fwd_sel_rs1_d = issue ? pos1 : 3'd0;
        fwd_sel_rs2_d = issue ? pos2 : 3'd0;
        stall_count_d = stall_count_q;
        if (load_use && (stall_count_q != {CNT_W{1'b1}})) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q         <= '0;
            load_q        <= '0;
            mem_q         <= '0;
            fwd_sel_rs1_q <= '0;
            fwd_sel_rs2_q <= '0;
            stall_count_q <= '0;
        end else if (!freeze) begin
            for (int k = N - 1; k > 0; k--) begin
                vld_q[k]  <= vld_q[k-1];
                load_q[k] <= load_q[k-1];
            end
            vld_q[0]      <= issue & id_reg_write & (id_rd_addr != '0);
            load_q[0]     <= issue & id_is_load;
            mem_q         <= {mem_q[0], issue & id_mem_op};
            fwd_sel_rs1_q <= fwd_sel_rs1_d;
            fwd_sel_rs2_q <= fwd_sel_rs2_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Destination addresses are qualified by vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (!freeze) begin
            for (int k = N - 1; k > 0; k--) begin
                rd_q[k] <= rd_q[k-1];
            end
            rd_q[0] <= id_rd_addr;
        end
    end

    assign stall_fetch  = stall;
    assign stall_decode = stall;
    assign freeze_all   = freeze;
    assign flush_decode = flush;
    assign fwd_sel_rs1  = fwd_sel_rs1_q;
    assign fwd_sel_rs2  = fwd_sel_rs2_q;
    assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Bench for pipeline_hazard_scoreboard: directed scenarios with literal expectations, then random
// instruction streams checked every cycle against a stage-array model of the pipeline.
`timescale 1ns/1ps
module tb_pipeline_hazard_scoreboard;
    localparam int N   = 2;
    localparam int LFS = 2;
    localparam int AW  = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, id_mem_op;
    logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic ex_branch_taken, dmem_ready;

    logic stall_fetch, stall_decode, freeze_all, flush_decode;
    logic [2:0] fwd_sel_rs1, fwd_sel_rs2;
    logic [31:0] stall_count;
    logic stall_fetch_s, stall_decode_s, freeze_all_s, flush_decode_s;
    logic [2:0] fwd_sel_rs1_s, fwd_sel_rs2_s;
    logic [2:0] stall_count_s;

    always #5 clk = ~clk;

    pipeline_hazard_scoreboard #(.NUM_FWD_STAGES(N), .LOAD_FWD_STAGE(LFS), .REG_ADDR_W(AW), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_mem_op(id_mem_op),
        .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready), .stall_fetch(stall_fetch),
        .stall_decode(stall_decode), .freeze_all(freeze_all), .flush_decode(flush_decode),
        .fwd_sel_rs1(fwd_sel_rs1), .fwd_sel_rs2(fwd_sel_rs2), .stall_count(stall_count));

    // Narrow counter copy to exercise saturation.
    pipeline_hazard_scoreboard #(.NUM_FWD_STAGES(N), .LOAD_FWD_STAGE(LFS), .REG_ADDR_W(AW), .CNT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd_addr(id_rd_addr),
        .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_mem_op(id_mem_op),
        .ex_branch_taken(ex_branch_taken), .dmem_ready(dmem_ready), .stall_fetch(stall_fetch_s),
        .stall_decode(stall_decode_s), .freeze_all(freeze_all_s), .flush_decode(flush_decode_s),
        .fwd_sel_rs1(fwd_sel_rs1_s), .fwd_sel_rs2(fwd_sel_rs2_s), .stall_count(stall_count_s));

    int n_pass = 0;
    int n_total = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Model: one slot per pipeline stage (0=EX .. N). rd is 0 for instructions that write nothing.
    typedef struct packed { logic v; logic [AW-1:0] rd; logic ld; logic mo; } ent_t;
    ent_t pipe [0:N];
    logic [2:0] m_fwd1, m_fwd2;
    int unsigned m_cnt;
    logic e_freeze, e_flush, e_loaduse, e_stall;
    logic [2:0] e_pos1, e_pos2;
    bit hold;

    function automatic void find(input logic [AW-1:0] src, input logic used,
                                 output logic [2:0] pos, output logic haz);
        pos = 3'd0;
        haz = 1'b0;
        if (used && src != 0) begin
            for (int s = 0; s < N; s++) begin
                if (pipe[s].v && pipe[s].rd == src) begin
                    pos = 3'(s + 1);
                    haz = pipe[s].ld && (s + 1 < LFS);
                    break;
                end
            end
        end
    endfunction

    function automatic void evaluate();
        logic h1, h2;
        find(id_rs1_addr, id_rs1_used, e_pos1, h1);
        find(id_rs2_addr, id_rs2_used, e_pos2, h2);
        e_freeze  = rst_n && pipe[1].v && pipe[1].mo && !dmem_ready;
        e_flush   = rst_n && ex_branch_taken && !e_freeze;
        e_loaduse = rst_n && id_valid && (h1 || h2) && !e_freeze && !e_flush;
        e_stall   = e_freeze || e_loaduse;
    endfunction

    function automatic void model_reset();
        for (int s = 0; s <= N; s++) pipe[s] = '0;
        m_fwd1 = 3'd0;
        m_fwd2 = 3'd0;
        m_cnt  = 0;
        hold   = 1'b0;
    endfunction

    function automatic void model_step();
        logic issue;
        evaluate();
        hold = e_stall;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (e_freeze) return;
        issue = id_valid && !e_stall && !e_flush;
        for (int s = N; s > 0; s--) pipe[s] = pipe[s-1];
        pipe[0] = issue ? {1'b1, (id_reg_write ? id_rd_addr : 5'd0), id_is_load, id_mem_op} : '0;
        m_fwd1 = issue ? e_pos1 : 3'd0;
        m_fwd2 = issue ? e_pos2 : 3'd0;
        if (e_loaduse) m_cnt++;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            evaluate();
            chk("stall_fetch", stall_fetch, e_stall);
            chk("stall_decode", stall_decode, e_stall);
            chk("freeze_all", freeze_all, e_freeze);
            chk("flush_decode", flush_decode, e_flush);
            chk("fwd_sel_rs1", fwd_sel_rs1, rst_n ? m_fwd1 : 3'd0);
            chk("fwd_sel_rs2", fwd_sel_rs2, rst_n ? m_fwd2 : 3'd0);
            chk("stall_count", stall_count, m_cnt);
            chk("sat_stall_decode", stall_decode_s, e_stall);
            chk("sat_fwd_sel_rs1", fwd_sel_rs1_s, rst_n ? m_fwd1 : 3'd0);
            chk("sat_stall_count", stall_count_s, (m_cnt > 7) ? 7 : m_cnt);
            chk("sat_flush_freeze", {flush_decode_s, freeze_all_s, stall_fetch_s, fwd_sel_rs2_s},
                {e_flush, e_freeze, e_stall, (rst_n ? m_fwd2 : 3'd0)});
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_instr(input logic v, input int rs1, input logic u1, input int rs2, input logic u2,
                             input int rd, input logic rw, input logic ld, input logic mo);
        id_valid     = v;
        id_rs1_addr  = AW'(rs1);
        id_rs1_used  = u1;
        id_rs2_addr  = AW'(rs2);
        id_rs2_used  = u2;
        id_rd_addr   = AW'(rd);
        id_reg_write = rw;
        id_is_load   = ld;
        id_mem_op    = mo;
    endtask

    task automatic rand_instr();
        int kind;
        kind = $urandom_range(0, 9);
        id_valid     = ($urandom_range(0, 99) < 85);
        id_rs1_addr  = AW'($urandom_range(0, 4));
        id_rs2_addr  = AW'($urandom_range(0, 4));
        id_rs1_used  = ($urandom_range(0, 9) != 0);
        id_rs2_used  = ($urandom_range(0, 2) != 0);
        id_rd_addr   = AW'($urandom_range(0, 4));
        id_is_load   = (kind < 4);
        id_mem_op    = (kind < 5);
        id_reg_write = (kind < 4) || ((kind > 4) && ($urandom_range(0, 7) != 0));
    endtask

    initial begin
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        ex_branch_taken = 1'b0;
        dmem_ready = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        ex_branch_taken = 1'b1;
        #1;
        chk("rst_stall", stall_decode, 0);
        chk("rst_flush", flush_decode, 0);
        chk("rst_fwd", {fwd_sel_rs1, fwd_sel_rs2}, 0);
        chk("rst_count", stall_count, 0);
        ex_branch_taken = 1'b0;
        chk_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // add x5,x1,x2 ; sub x6,x5,x3
        set_instr(1, 1, 1, 2, 1, 5, 1, 0, 0);
        tick();
        set_instr(1, 5, 1, 3, 1, 6, 1, 0, 0);
        #1 chk("t1_nostall", stall_decode, 0);
        tick();
        chk("t1_fwd1", fwd_sel_rs1, 1);
        chk("t1_fwd2", fwd_sel_rs2, 0);

        // lw x6,0(x1) ; add x7,x6,x6
        set_instr(1, 1, 1, 0, 0, 6, 1, 1, 1);
        tick();
        set_instr(1, 6, 1, 6, 1, 7, 1, 0, 0);
        #1 chk("t2_stall", stall_decode, 1);
        chk("t2_stall_fetch", stall_fetch, 1);
        tick();
        chk("t2_released", stall_decode, 0);
        chk("t2_count", stall_count, 1);
        tick();
        chk("t2_fwd1", fwd_sel_rs1, 2);
        chk("t2_fwd2", fwd_sel_rs2, 2);

        // addi x0,x1,5 ; add x2,x0,x0
        set_instr(1, 1, 1, 0, 0, 0, 1, 0, 0);
        tick();
        set_instr(1, 0, 1, 0, 1, 2, 1, 0, 0);
        #1 chk("t3_nostall", stall_decode, 0);
        tick();
        chk("t3_fwd", {fwd_sel_rs1, fwd_sel_rs2}, 0);

        // add x8 ; lw x9,0(x8) ; add x10,x8,x1 ; then lw waits in MEM for 3 cycles
        set_instr(1, 1, 1, 2, 1, 8, 1, 0, 0);
        tick();
        set_instr(1, 8, 1, 0, 0, 9, 1, 1, 1);
        tick();
        chk("t4_lw_fwd1", fwd_sel_rs1, 1);
        set_instr(1, 8, 1, 1, 1, 10, 1, 0, 0);
        #1 chk("t4_nostall", stall_decode, 0);
        tick();
        chk("t4_add_fwd1", fwd_sel_rs1, 2);
        set_instr(0, 0, 0, 0, 0, 0, 0, 0, 0);
        dmem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t4_freeze", freeze_all, 1);
            chk("t4_frz_stall", stall_decode, 1);
            chk("t4_frz_fwd1", fwd_sel_rs1, 2);
            chk("t4_frz_count", stall_count, 1);
            tick();
        end
        dmem_ready = 1'b1;
        #1 chk("t4_resume", freeze_all, 0);
        tick();

        // lw x11 ; add x12,x11,x0 with a taken branch in the same cycle
        set_instr(1, 1, 1, 0, 0, 11, 1, 1, 1);
        tick();
        set_instr(1, 11, 1, 0, 1, 12, 1, 0, 0);
        ex_branch_taken = 1'b1;
        #1 chk("t5_flush", flush_decode, 1);
        chk("t5_nostall", stall_decode, 0);
        tick();
        ex_branch_taken = 1'b0;
        chk("t5_count", stall_count, 1);
        chk("t5_fwd1", fwd_sel_rs1, 0);

        // reset in the middle of a load-use stall
        set_instr(1, 1, 1, 0, 0, 13, 1, 1, 1);
        tick();
        set_instr(1, 13, 1, 13, 1, 14, 1, 0, 0);
        #1 chk("t6_stall", stall_decode, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_stall", stall_decode, 0);
        chk("t6_rst_count", stall_count, 0);
        chk("t6_rst_fwd", {fwd_sel_rs1, fwd_sel_rs2}, 0);
        tick();
        rst_n = 1'b1;
        set_instr(1, 1, 1, 2, 1, 5, 1, 0, 0);
        tick();
        set_instr(1, 5, 1, 3, 1, 6, 1, 0, 0);
        #1 chk("t6_nostall", stall_decode, 0);
        tick();
        chk("t6_fwd1", fwd_sel_rs1, 1);
        chk("t6_fwd2", fwd_sel_rs2, 0);
        chk("t6_count", stall_count, 0);

        for (int c = 0; c < 3000; c++) begin
            if (!hold) rand_instr();
            ex_branch_taken = ($urandom_range(0, 99) < 8);
            dmem_ready = ($urandom_range(0, 99) < 70);
            tick();
        end
        chk("sat_reached", stall_count_s, (m_cnt > 7) ? 7 : m_cnt);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
